// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Fetches always read the full word.
    localparam logic [3:0]  BE_FULL     = 4'hF;

    // Read data returned to the requester when a grant times out.
    localparam logic [63:0] ABORT_RDATA = 64'd0;

endpackage

// File: rtl/arb_perf_cnt.sv
// 32-bit wrapping event counter with synchronous clear.
module arb_perf_cnt (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    // Count enabled cycles; wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data requests win over fetch, except when MAX_D_RUN data grants in a row have
// already starved a pending fetch. Optional performance counters are compiled
// in when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MAX_D_RUN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    output logic                  o_if_valid,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [3:0]            i_d_be,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic                  o_d_valid,
    output logic                  o_stall,
    output logic                  o_err,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           o_perf_if_cnt,
    output logic [31:0]           o_perf_d_cnt,
    output logic [31:0]           o_perf_stall_cnt
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam int unsigned RW = $clog2(MAX_D_RUN + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_D_RUN);
    localparam logic [DATA_WIDTH-1:0] ABORT_VAL = DATA_WIDTH'(ABORT_RDATA);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  w_grant_i;
    logic                  w_grant_d;
    logic                  w_in_gnt;
    logic                  w_tmo_hit;
    logic                  w_if_valid;
    logic                  w_d_valid;
    logic                  w_stall;
    logic                  r_sel_d;     // current/last grant belongs to the data port
    logic [TW-1:0]         r_tmo;
    logic [RW-1:0]         r_run;
    logic                  r_err;
    logic                  r_mem_we;
    logic [3:0]            r_mem_be;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    assign w_in_gnt = (r_state == GNT_I) || (r_state == GNT_D);

    // Next-state decode: grant selection in IDLE, ack/timeout exit from a grant.
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_tmo_hit    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_d_req && !(i_if_req && (r_run == RUN_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_state_next = GNT_D;
                end else if (i_if_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (i_mem_ack) begin
                    w_state_next = RESP;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_hit    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, grant attributes, run/timeout counters and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel_d     <= 1'b0;
            r_tmo       <= '0;
            r_run       <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_tmo   <= w_in_gnt ? r_tmo + 1'b1 : '0;
            if (w_grant_d) begin
                r_sel_d     <= 1'b1;
                r_mem_we    <= i_d_we;
                r_mem_be    <= i_d_be;
                r_mem_addr  <= i_d_addr;
                r_mem_wdata <= i_d_wdata;
                // Only data grants that bypass a waiting fetch count toward starvation.
                if (!i_if_req) begin
                    r_run <= '0;
                end else if (r_run != RUN_MAX) begin
                    r_run <= r_run + 1'b1;
                end
            end
            if (w_grant_i) begin
                r_sel_d     <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= BE_FULL;
                r_mem_addr  <= i_if_addr;
                r_mem_wdata <= '0;
                r_run       <= '0;
            end
            if (w_tmo_hit) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read-data capture on ack, or the abort value on timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else if (w_in_gnt && i_mem_ack) begin
            if (!r_sel_d) begin
                r_if_rdata <= i_mem_rdata;
            end else if (!r_mem_we) begin
                r_d_rdata <= i_mem_rdata;
            end
        end else if (w_tmo_hit) begin
            if (!r_sel_d) begin
                r_if_rdata <= ABORT_VAL;
            end else begin
                r_d_rdata <= ABORT_VAL;
            end
        end
    end

    assign w_if_valid = (r_state == RESP) && !r_sel_d;
    assign w_d_valid  = (r_state == RESP) && r_sel_d;
    assign w_stall    = (i_if_req && !w_if_valid) || (i_d_req && !w_d_valid);

    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = w_if_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = w_d_valid;
    assign o_stall     = w_stall;
    assign o_err       = r_err;
    assign o_mem_req   = w_in_gnt;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

`ifdef ARB_PERF_CNT_EN
    arb_perf_cnt u_perf_if (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_en  (w_grant_i),
        .o_cnt (o_perf_if_cnt)
    );

    arb_perf_cnt u_perf_d (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_en  (w_grant_d),
        .o_cnt (o_perf_d_cnt)
    );

    arb_perf_cnt u_perf_stall (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_en  (w_stall),
        .o_cnt (o_perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder with programmable ack delay,
// per-port expected-read-data queues checked on each valid pulse.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_cnt;
    logic [31:0] perf_d_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_delay = 1;   // 0 = memory never acks
    int          req_cycles = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] mon_exp;

    mem_port_arbiter u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_valid  (if_valid),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_be      (d_be),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_rdata   (d_rdata),
        .o_d_valid   (d_valid),
        .o_stall     (stall),
        .o_err       (err),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .o_perf_if_cnt    (perf_if_cnt),
        .o_perf_d_cnt     (perf_d_cnt),
        .o_perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h0050_0093;
        if (a == 32'h0001_0000) return 32'h1234_5678;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ack after ack_delay cycles of mem_req.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                req_cycles++;
                if (ack_delay != 0 && req_cycles == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_val(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                req_cycles = 0;
                mem_ack    = 1'b0;
            end
        end
    end

    // Scoreboard: pop the expected read data on every valid pulse.
    always @(negedge clk) begin
        if (if_valid) begin
            if (if_q.size() == 0) begin
                check_eq("if_unexpected_valid", {31'd0, if_valid}, 32'd0);
            end else begin
                mon_exp = if_q.pop_front();
                check_eq("if_rdata", if_rdata, mon_exp);
            end
        end
        if (d_valid) begin
            if (d_q.size() == 0) begin
                check_eq("d_unexpected_valid", {31'd0, d_valid}, 32'd0);
            end else begin
                mon_exp = d_q.pop_front();
                check_eq("d_rdata", d_rdata, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] e_req;
        logic [3:0] e_val;
        logic [3:0] e_stl;
        int d_cyc;
        int i_cyc;
        int nd;
        int nreq;
        bit found;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_d_rdata", d_rdata, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Fetch only, ack after 2 cycles.
        ack_delay = 2;
        e_req = 4'b0110; e_val = 4'b1000; e_stl = 4'b0111;
        if_req = 1'b1; if_addr = 32'hBFC0_0000;
        if_q.push_back(32'h0050_0093);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("fetch_mem_req_c%0d", c), {31'd0, mem_req}, {31'd0, e_req[c]});
            check_eq($sformatf("fetch_valid_c%0d", c), {31'd0, if_valid}, {31'd0, e_val[c]});
            check_eq($sformatf("fetch_stall_c%0d", c), {31'd0, stall}, {31'd0, e_stl[c]});
            if (c == 1) begin
                check_eq("fetch_mem_addr", mem_addr, 32'hBFC0_0000);
                check_eq("fetch_mem_be", {28'd0, mem_be}, 32'hF);
                check_eq("fetch_mem_we", {31'd0, mem_we}, 32'd0);
            end
        end
        tick();
        if_req = 1'b0;
        repeat (2) tick();

        // Simultaneous load and fetch: data first.
        ack_delay = 1;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0001_0000;
        if_q.push_back(mem_val(32'h0000_0400));
        d_q.push_back(32'h1234_5678);
        d_cyc = -1; i_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_valid) begin
                d_cyc = c;
                check_eq("simul_stall_at_dvalid", {31'd0, stall}, 32'd1);
            end
            if (if_valid) begin
                i_cyc = c;
                break;
            end
            tick();
            if (d_valid) d_req = 1'b0;
        end
        check_eq("simul_d_cycle", d_cyc, 32'd2);
        check_eq("simul_i_cycle", i_cyc, 32'd5);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();

        // Store: attributes stable, d_rdata keeps the last load.
        ack_delay = 3;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_0020;
        d_wdata = 32'hAABB_CCDD;
        d_q.push_back(32'h1234_5678);
        nreq = 0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                check_eq("store_mem_be", {28'd0, mem_be}, 32'h3);
                check_eq("store_mem_wdata", mem_wdata, 32'hAABB_CCDD);
                check_eq("store_mem_we", {31'd0, mem_we}, 32'd1);
            end
            if (d_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("store_valid_seen", {31'd0, found}, 32'd1);
        check_eq("store_req_cycles", nreq, 32'd3);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) tick();

        // Starvation: fetch forced after MAX_D_RUN data grants.
        ack_delay = 1;
        if_req = 1'b1; if_addr = 32'h0000_0800;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0030;
        for (int k = 0; k < 4; k++) d_q.push_back(mem_val(32'h0000_0030));
        if_q.push_back(mem_val(32'h0000_0800));
        nd = 0; found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (d_valid) nd++;
            if (if_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("starve_if_seen", {31'd0, found}, 32'd1);
        check_eq("starve_d_grants", nd, 32'd4);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();

        // Timeout on a fetch with no ack.
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        if_q.push_back(32'd0);
        nreq = 0; found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_req) nreq++;
            if (if_valid) begin
                found = 1'b1;
                check_eq("tmo_err_at_valid", {31'd0, err}, 32'd1);
                break;
            end
            tick();
        end
        check_eq("tmo_valid_seen", {31'd0, found}, 32'd1);
        check_eq("tmo_req_cycles", nreq, 32'd16);
        tick();
        if_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("tmo_err_sticky", {31'd0, err}, 32'd1);
        check_eq("tmo_mem_req_low", {31'd0, mem_req}, 32'd0);

        // Reset in the cycle after a data grant.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0040;
        tick();
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check_eq("rstmid_mem_req_before", {31'd0, mem_req}, 32'd1);
        check_eq("rstmid_mem_addr_before", mem_addr, 32'h0000_0040);
        tick();
        @(negedge clk);
        check_eq("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rstmid_d_valid", {31'd0, d_valid}, 32'd0);
        check_eq("rstmid_err", {31'd0, err}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check_eq("end_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("end_if_q_empty", 32'(if_q.size()), 32'd0);
        check_eq("end_d_q_empty", 32'(d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
